// File: rtl/if_prefetch_buffer_pkg.sv
// Shared types and constants for the instruction prefetch buffer.
package if_prefetch_buffer_pkg;

    localparam int              XLEN             = 32;
    localparam int              PC_INC           = 4;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/if_prefetch_buffer_if.sv
// Redirect, instruction-memory and IF/ID handshake bundle of the prefetch buffer.
interface if_prefetch_buffer_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  redirect_valid_i;
    logic [DATA_WIDTH-1:0] redirect_pc_i;
    logic                  imem_req_valid_o;
    logic [DATA_WIDTH-1:0] imem_req_addr_o;
    logic                  imem_req_ready_i;
    logic                  imem_rsp_valid_i;
    logic [DATA_WIDTH-1:0] imem_rsp_data_i;
    logic                  IF_valid_o;
    logic [DATA_WIDTH-1:0] IF_instruction_o;
    logic [DATA_WIDTH-1:0] IF_pc_o;
    logic [DATA_WIDTH-1:0] IF_pc_plus4_o;
    logic                  ID_ready_i;

    modport master (
        input  redirect_valid_i, redirect_pc_i,
        output imem_req_valid_o, imem_req_addr_o,
        input  imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i,
        output IF_valid_o, IF_instruction_o, IF_pc_o, IF_pc_plus4_o,
        input  ID_ready_i
    );

    modport slave (
        output redirect_valid_i, redirect_pc_i,
        input  imem_req_valid_o, imem_req_addr_o,
        output imem_req_ready_i, imem_rsp_valid_i, imem_rsp_data_i,
        input  IF_valid_o, IF_instruction_o, IF_pc_o, IF_pc_plus4_o,
        output ID_ready_i
    );
endinterface

// File: rtl/if_prefetch_buffer_chk.sv
// Run-time checks on the prefetch buffer credit scheme.
module if_prefetch_buffer_chk #(
    parameter int OW              = 2,
    parameter int MAX_OUTSTANDING = 2
) (
    input logic          clk,
    input logic          rst_n,
    input logic          push,
    input logic          full,
    input logic [OW-1:0] outstanding
);
    // The credit rule reserves a FIFO slot for every response, so a full push is a design bug.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));
    a_outstanding: assert property (@(posedge clk) disable iff (!rst_n)
                                    outstanding <= OW'(MAX_OUTSTANDING));
endmodule

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO with flush; head entry is visible combinationally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [CW-1:0]    count,
    output logic [WIDTH-1:0] head_data,
    output logic             full
);
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Qualify handshakes against occupancy so pointers can never run past each other.
    always_comb begin
        full      = (count_r == CW'(DEPTH));
        do_push_s = push & ~full;
        do_pop_s  = pop & (count_r != CW'(0));
        count     = count_r;
        head_data = mem_r[rd_ptr_r];
    end

    // Storage, pointers and occupancy; flush empties the queue without touching storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= WIDTH'(0);
            end
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= CW'(0);
        end else if (flush) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= CW'(0);
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: rtl/if_prefetch_buffer.sv
// Instruction prefetch queue: issues sequential fetches ahead of decode, flushes on redirect
// and silently drops responses to requests made before the redirect.
module if_prefetch_buffer
    import if_prefetch_buffer_pkg::*;
#(
    parameter int                    DATA_WIDTH      = XLEN,
    parameter int                    DEPTH           = 4,
    parameter int                    MAX_OUTSTANDING = 2,
    parameter logic [DATA_WIDTH-1:0] RESET_PC        = RESET_PC_DEFAULT
) (
    input logic                  clk,
    input logic                  rst_n,
    if_prefetch_buffer_if.master bus
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int OW = $clog2(MAX_OUTSTANDING + 1);

    logic [DATA_WIDTH-1:0] fetch_pc_r, fetch_pc_nxt_s;
    logic [DATA_WIDTH-1:0] rsp_pc_r, rsp_pc_nxt_s;
    logic [DATA_WIDTH-1:0] redirect_pc_s;
    logic [OW-1:0]         outstanding_r, outstanding_nxt_s;
    logic [OW-1:0]         discard_cnt_r, discard_cnt_nxt_s;
    logic [CW-1:0]         count_s;
    logic                  redirect_s, credit_ok_s, req_valid_s, req_fire_s, rsp_fire_s;
    logic                  push_s, pop_s, full_s;
    fetch_entry_t          push_entry_s, head_entry_s;

    // Request credit, response classification and FIFO handshakes.
    always_comb begin
        redirect_s        = bus.redirect_valid_i;
        redirect_pc_s     = bus.redirect_pc_i & ~DATA_WIDTH'(3);
        credit_ok_s       = (outstanding_r < OW'(MAX_OUTSTANDING)) &&
                            ((int'(count_s) + int'(outstanding_r)) < DEPTH);
        req_valid_s       = rst_n & ~redirect_s & credit_ok_s;
        req_fire_s        = req_valid_s & bus.imem_req_ready_i;
        rsp_fire_s        = bus.imem_rsp_valid_i;
        push_s            = rsp_fire_s & ~redirect_s & (discard_cnt_r == OW'(0));
        pop_s             = (count_s != CW'(0)) & bus.ID_ready_i & ~redirect_s;
        outstanding_nxt_s = outstanding_r + OW'(req_fire_s) - OW'(rsp_fire_s);
        push_entry_s      = '{instr: bus.imem_rsp_data_i, pc: rsp_pc_r};
    end

    // PC and stale-response bookkeeping; a redirect re-targets both PCs and marks all in-flight work stale.
    always_comb begin
        fetch_pc_nxt_s    = fetch_pc_r;
        rsp_pc_nxt_s      = rsp_pc_r;
        discard_cnt_nxt_s = discard_cnt_r;
        if (redirect_s) begin
            fetch_pc_nxt_s    = redirect_pc_s;
            rsp_pc_nxt_s      = redirect_pc_s;
            discard_cnt_nxt_s = outstanding_nxt_s;
        end else begin
            if (req_fire_s) begin
                fetch_pc_nxt_s = fetch_pc_r + DATA_WIDTH'(PC_INC);
            end else begin
                fetch_pc_nxt_s = fetch_pc_r;
            end
            if (rsp_fire_s && (discard_cnt_r != OW'(0))) begin
                discard_cnt_nxt_s = discard_cnt_r - OW'(1);
            end else if (push_s) begin
                rsp_pc_nxt_s = rsp_pc_r + DATA_WIDTH'(PC_INC);
            end else begin
                rsp_pc_nxt_s = rsp_pc_r;
            end
        end
    end

    // Fetch/response PCs, outstanding credit and stale-response counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_r    <= RESET_PC;
            rsp_pc_r      <= RESET_PC;
            outstanding_r <= OW'(0);
            discard_cnt_r <= OW'(0);
        end else begin
            fetch_pc_r    <= fetch_pc_nxt_s;
            rsp_pc_r      <= rsp_pc_nxt_s;
            outstanding_r <= outstanding_nxt_s;
            discard_cnt_r <= discard_cnt_nxt_s;
        end
    end

    sync_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .push_data (push_entry_s),
        .pop       (pop_s),
        .flush     (redirect_s),
        .count     (count_s),
        .head_data (head_entry_s),
        .full      (full_s)
    );

    if_prefetch_buffer_chk #(
        .OW              (OW),
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_chk (
        .clk         (clk),
        .rst_n       (rst_n),
        .push        (push_s),
        .full        (full_s),
        .outstanding (outstanding_r)
    );

    // Output drive; everything is forced low while reset is held.
    always_comb begin
        bus.imem_req_valid_o = req_valid_s;
        bus.IF_valid_o       = rst_n & (count_s != CW'(0));
        if (rst_n) begin
            bus.imem_req_addr_o  = fetch_pc_r;
            bus.IF_instruction_o = head_entry_s.instr;
            bus.IF_pc_o          = head_entry_s.pc;
            bus.IF_pc_plus4_o    = head_entry_s.pc + DATA_WIDTH'(PC_INC);
        end else begin
            bus.imem_req_addr_o  = DATA_WIDTH'(0);
            bus.IF_instruction_o = DATA_WIDTH'(0);
            bus.IF_pc_o          = DATA_WIDTH'(0);
            bus.IF_pc_plus4_o    = DATA_WIDTH'(0);
        end
    end
endmodule

// File: tb/tb_if_prefetch_buffer.sv
// Bench for if_prefetch_buffer: reset/stall vector table, redirect corner cases and a random
// run checked against an in-order program-stream model with a variable-latency memory.
module tb_if_prefetch_buffer;
    localparam int          DW       = 32;
    localparam int          DEPTH    = 4;
    localparam int          MAXO     = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    if_prefetch_buffer_if #(.DATA_WIDTH(DW)) bus();

    if_prefetch_buffer #(
        .DATA_WIDTH      (DW),
        .DEPTH           (DEPTH),
        .MAX_OUTSTANDING (MAXO),
        .RESET_PC        (RESET_PC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    typedef struct {
        logic        id_ready;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic        exp_req_valid;
        logic [31:0] exp_addr;
    } vec_t;

    mreq_t       mq[$];
    vec_t        tbl[20];
    int          cyc, lat, pops;
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] exp_pc;
    logic        s_req_valid, s_valid;
    logic [31:0] s_addr, s_pc, s_instr, s_plus4;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hDEAD_0013;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One clock cycle: memory answers, outputs are sampled and checked against the stream model.
    task automatic step();
        int outst;
        outst = mq.size();
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            bus.imem_rsp_valid_i = 1'b1;
            bus.imem_rsp_data_i  = mem_word(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            bus.imem_rsp_valid_i = 1'b0;
            bus.imem_rsp_data_i  = $urandom;
        end
        #1;
        s_req_valid = bus.imem_req_valid_o;
        s_addr      = bus.imem_req_addr_o;
        s_valid     = bus.IF_valid_o;
        s_pc        = bus.IF_pc_o;
        s_instr     = bus.IF_instruction_o;
        s_plus4     = bus.IF_pc_plus4_o;
        if (s_req_valid) begin
            check("req_credit", 32'(outst < MAXO), 32'd1);
            check("req_align", 32'(s_addr[1:0]), 32'd0);
        end
        if (bus.redirect_valid_i) begin
            check("req_during_redirect", 32'(s_req_valid), 32'd0);
            exp_pc = bus.redirect_pc_i & ~32'd3;
        end else if (s_valid && bus.ID_ready_i) begin
            check("stream_pc", s_pc, exp_pc);
            check("stream_instr", s_instr, mem_word(exp_pc));
            check("stream_pc_plus4", s_plus4, exp_pc + 32'd4);
            exp_pc = exp_pc + 32'd4;
            pops++;
        end
        if (s_req_valid && bus.imem_req_ready_i) begin
            mq.push_back('{addr: s_addr, due: cyc + lat});
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_req_valid"}, 32'(bus.imem_req_valid_o), 32'd0);
        check({name, "_req_addr"}, bus.imem_req_addr_o, 32'd0);
        check({name, "_if_valid"}, 32'(bus.IF_valid_o), 32'd0);
        check({name, "_instr"}, bus.IF_instruction_o, 32'd0);
        check({name, "_pc"}, bus.IF_pc_o, 32'd0);
        check({name, "_pc_plus4"}, bus.IF_pc_plus4_o, 32'd0);
    endtask

    task automatic do_reset();
        rst_n                = 1'b0;
        bus.redirect_valid_i = 1'b0;
        bus.redirect_pc_i    = 32'd0;
        bus.imem_req_ready_i = 1'b1;
        bus.imem_rsp_valid_i = 1'b0;
        bus.imem_rsp_data_i  = 32'd0;
        bus.ID_ready_i       = 1'b1;
        mq.delete();
        exp_pc = RESET_PC;
        @(posedge clk);
        #1;
        check_outputs_zero("in_reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic wait_valid(input string name, input logic [31:0] pc);
        int k;
        k = 0;
        do begin
            step();
            k++;
        end while (!s_valid && k < 30);
        check({name, "_valid"}, 32'(s_valid), 32'd1);
        check({name, "_pc"}, s_pc, pc);
        check({name, "_instr"}, s_instr, mem_word(pc));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int found;
        // Zero-wait memory after reset release, then a 10-cycle decode stall and release.
        tbl[0]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h00};
        tbl[1]  = '{1'b1, 1'b0, 32'h00, 1'b1, 32'h04};
        tbl[2]  = '{1'b1, 1'b1, 32'h00, 1'b1, 32'h08};
        tbl[3]  = '{1'b1, 1'b1, 32'h04, 1'b1, 32'h0C};
        tbl[4]  = '{1'b1, 1'b1, 32'h08, 1'b1, 32'h10};
        tbl[5]  = '{1'b1, 1'b1, 32'h0C, 1'b1, 32'h14};
        tbl[6]  = '{1'b0, 1'b1, 32'h10, 1'b1, 32'h18};
        tbl[7]  = '{1'b0, 1'b1, 32'h10, 1'b1, 32'h1C};
        for (int i = 8; i < 16; i++) begin
            tbl[i] = '{1'b0, 1'b1, 32'h10, 1'b0, 32'h20};
        end
        tbl[16] = '{1'b1, 1'b1, 32'h10, 1'b0, 32'h20};
        tbl[17] = '{1'b1, 1'b1, 32'h14, 1'b1, 32'h20};
        tbl[18] = '{1'b1, 1'b1, 32'h18, 1'b1, 32'h24};
        tbl[19] = '{1'b1, 1'b1, 32'h1C, 1'b1, 32'h28};

        lat = 1;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            bus.ID_ready_i = tbl[i].id_ready;
            step();
            check("tbl_if_valid", 32'(s_valid), 32'(tbl[i].exp_valid));
            check("tbl_req_valid", 32'(s_req_valid), 32'(tbl[i].exp_req_valid));
            check("tbl_req_addr", s_addr, tbl[i].exp_addr);
            if (tbl[i].exp_valid) begin
                check("tbl_pc", s_pc, tbl[i].exp_pc);
                check("tbl_pc_plus4", s_plus4, tbl[i].exp_pc + 32'd4);
                check("tbl_instr", s_instr, mem_word(tbl[i].exp_pc));
            end
        end

        // Latency 3: redirect while 0x8 and 0xC are in flight; both must be dropped.
        lat = 3;
        do_reset();
        found = 0;
        for (int k = 0; k < 30 && found == 0; k++) begin
            step();
            if (mq.size() == 2 && mq[0].addr == 32'h8 && mq[1].addr == 32'hC) begin
                found = 1;
            end
        end
        check("lat3_two_in_flight", 32'(found), 32'd1);
        bus.redirect_valid_i = 1'b1;
        bus.redirect_pc_i    = 32'h0000_0100;
        step();
        bus.redirect_valid_i = 1'b0;
        wait_valid("lat3_redirect", 32'h0000_0100);

        // Redirect in the same cycle the response for 0x4 arrives.
        lat = 1;
        do_reset();
        found = 0;
        for (int k = 0; k < 30 && found == 0; k++) begin
            step();
            if (mq.size() > 0 && mq[0].addr == 32'h4 && mq[0].due <= cyc) begin
                found = 1;
            end
        end
        check("same_cycle_setup", 32'(found), 32'd1);
        bus.redirect_valid_i = 1'b1;
        bus.redirect_pc_i    = 32'h0000_0100;
        step();
        bus.redirect_valid_i = 1'b0;
        wait_valid("same_cycle_redirect", 32'h0000_0100);

        // Unaligned redirect target is word-aligned.
        bus.redirect_valid_i = 1'b1;
        bus.redirect_pc_i    = 32'h0000_0206;
        step();
        bus.redirect_valid_i = 1'b0;
        step();
        check("unaligned_req_addr", s_addr, 32'h0000_0204);
        wait_valid("unaligned_redirect", 32'h0000_0204);

        // Reset with the FIFO half full and one request outstanding.
        lat = 1;
        do_reset();
        bus.ID_ready_i = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
        end
        check("midreset_setup_valid", 32'(s_valid), 32'd1);
        check("midreset_setup_outstanding", 32'(mq.size()), 32'd1);
        rst_n                = 1'b0;
        bus.imem_rsp_valid_i = 1'b0;
        #1;
        check_outputs_zero("midreset");
        mq.delete();
        exp_pc = RESET_PC;
        @(posedge clk);
        #1;
        rst_n          = 1'b1;
        cyc            = 0;
        bus.ID_ready_i = 1'b1;
        step();
        check("post_reset_req_valid", 32'(s_req_valid), 32'd1);
        check("post_reset_req_addr", s_addr, RESET_PC);

        // Random memory latency, ready, decode backpressure and redirects.
        do_reset();
        pops = 0;
        for (int i = 0; i < 3000; i++) begin
            lat                  = $urandom_range(1, 4);
            bus.imem_req_ready_i = ($urandom_range(0, 3) != 0);
            bus.ID_ready_i       = ($urandom_range(0, 3) != 0);
            bus.redirect_valid_i = ($urandom_range(0, 29) == 0);
            bus.redirect_pc_i    = $urandom & 32'h0000_0FFF;
            step();
        end
        bus.redirect_valid_i = 1'b0;
        check("random_progress", 32'(pops > 300), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
